hyperbus_tf_sched: RTL and testbench
====================================

# hyperbus_tf_sched

Transfer scheduler in front of the HyperBus PHY. Shares the single PHY transfer port (`hyper_tf_t`) between `NumReq` requesters using round-robin arbitration. Keeps a granted transfer exclusive until the PHY reports completion, then enforces the configured read-write recovery gap before the next grant. Sits between the AXI front-end channel splitters and the PHY FSM; `grant_id_o` steers TX/RX/B data routing.

## Interface

Parameters:
- `NumReq`, 2, number of requesters; must be ≥ 2.
- `IdWidth`, `$clog2(NumReq)`, width of `grant_id_o`.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cfg_i`  in  `hyper_cfg_t`  configuration; only `t_read_write_recovery` is used.
- `req_tf_i`  in  `NumReq` × `hyper_tf_t`  per-requester transfer descriptor.
- `req_valid_i`  in  `NumReq`  per-requester request valid.
- `req_ready_o`  out  `NumReq`  per-requester accept, one-hot or zero.
- `phy_tf_o`  out  `hyper_tf_t`  latched descriptor presented to the PHY.
- `phy_tf_valid_o`  out  1  descriptor valid to the PHY.
- `phy_tf_ready_i`  in  1  PHY accepts the descriptor.
- `phy_done_i`  in  1  single-cycle pulse from the PHY when the current transfer finishes (last beat / B).
- `grant_id_o`  out  `IdWidth`  index of the requester that owns the PHY.
- `busy_o`  out  1  high in every state except Idle.

## Operation

- FSM states: Idle, Issue, Active, Recover.
- **Idle:**
  - If any `req_valid_i` bit is set, pick the winner round-robin: the search starts at `(last_grant+1) mod NumReq`.
  - Assert `req_ready_o[winner]` combinationally in the same cycle.
  - On that edge: latch `req_tf_i[winner]` into `phy_tf_o`, set `grant_id_o=winner`, set `last_grant=winner`, go to Issue.
  - With no valid requests, stay in Idle.
- **Issue:**
  - `phy_tf_valid_o=1`, held until `phy_tf_ready_i`.
  - `phy_tf_o` is stable while valid.
  - On handshake, go to Active.
- **Active:**
  - Wait for `phy_done_i`.
  - When it arrives, latch `R = cfg_i.t_read_write_recovery`.
  - If R=0, go to Idle; otherwise load the counter with R and go to Recover.
- **Recover:**
  - Decrement the counter each cycle.
  - When the counter reaches 1 (i.e. after R cycles in Recover), go to Idle.
  - Changes to `cfg_i` during Recover do not affect the running count.
- `phy_done_i` is ignored outside Active. The PHY cannot complete a transfer it has not accepted.
- `req_ready_o` is all-zero outside Idle. A request whose valid drops before it is granted is simply not served; no state is kept for it.
- `phy_tf_o` and `grant_id_o` keep their last value in Idle. They are meaningful only while `busy_o=1`.
- Round-robin pointer:
  - Updates only on a grant.
  - Each continuously requesting requester is served at least once per `NumReq` grants.
- Reset values:
  - State Idle.
  - `phy_tf_o` = 0.
  - `phy_tf_valid_o` = 0.
  - `req_ready_o` = 0.
  - `grant_id_o` = 0.
  - `busy_o` = 0.
  - `last_grant` = `NumReq-1`, so requester 0 wins first.
  - Counter = 0.
- Reset asserted mid-transfer forces Idle immediately (asynchronous). No pending descriptor is retained.

## Timing

- Accept at edge 0 (Idle, ready high); `phy_tf_valid_o` high from cycle 1.
- With `phy_tf_ready_i` high in cycle 1, the state is Active from cycle 2.
- `phy_done_i` sampled in cycle N:
  - R=0: Idle in cycle N+1; the next `req_ready_o` can assert in cycle N+1.
  - R>0: Recover in cycles N+1..N+R; Idle in cycle N+R+1.
- Minimum spacing between two grants is 3 cycles (Idle, Issue, Active with immediate done).
- `busy_o` rises in the cycle after the grant and falls in the first Idle cycle.
- Recovery counter width is 4 bits, matching `t_read_write_recovery`. R=15 gives exactly 15 Recover cycles. No wrap is possible because the counter is loaded only from a 4-bit field.

## Test plan

- **Reset:** hold `rst_i` for 3 cycles with all valids high → all outputs 0 during reset. The first grant after release goes to requester 0, and `req_ready_o`=2'b01 in the first Idle cycle.
- **Single transfer:** requester 1 presents `{write=1, burst=7, address=0x100}`, PHY ready immediately, `phy_done_i` 5 cycles later, R=0.
  - Required: `phy_tf_o` matches the descriptor.
  - Required: `phy_tf_valid_o` is high for exactly 1 cycle.
  - Required: `grant_id_o`=1.
  - Required: `busy_o` falls in the cycle after done.
- **Round-robin:** both requesters valid continuously (`NumReq=2`), R=0 → grants alternate 0,1,0,1 over 4 transfers.
- **Recovery gap:** R=3; `phy_done_i` at cycle N while the other requester is waiting → Recover for cycles N+1..N+3, then `req_ready_o` asserts at N+4. Changing `cfg_i` to R=0 at N+1 does not shorten the gap.
- **PHY backpressure:** hold `phy_tf_ready_i` low for 6 cycles → `phy_tf_valid_o` stays high and `phy_tf_o` stays stable throughout. A `phy_done_i` pulse injected during Issue is ignored (no state change).
- **Mid-op reset:** assert `rst_i` while in Active → all outputs 0 immediately. After release, the first grant goes to requester 0 and the aborted transfer is not re-issued.

Source files
------------

// File: rtl/hyperbus_tf_sched.sv
// -----------------------------------------------------------------------------
// hyperbus_tf_sched_pkg
//   Descriptor and configuration types shared by the HyperBus front-end, this
//   scheduler and the PHY. Ports carry them as flat vectors of the same width.
//
// hyperbus_tf_sched
//   Round-robin scheduler sharing the single HyperBus PHY transfer port between
//   NumReq requesters. A granted transfer owns the PHY until phy_done_i, then
//   the configured read-write recovery gap is inserted before the next grant.
//
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     cfg_i             hyper_cfg_t (only t_read_write_recovery is used)
//     req_tf_i          NumReq packed hyper_tf_t descriptors, requester i at
//                       bits [i*TfWidth +: TfWidth]
//     req_valid_i       per-requester request valid
//     req_ready_o       per-requester accept, one-hot or zero
//     phy_tf_o          latched descriptor to the PHY
//     phy_tf_valid_o    descriptor valid to the PHY
//     phy_tf_ready_i    PHY accepts the descriptor
//     phy_done_i        PHY transfer-complete pulse
//     grant_id_o        requester currently owning the PHY
//     busy_o            high in every state except Idle
// -----------------------------------------------------------------------------

package hyperbus_tf_sched_pkg;

    typedef struct packed {
        logic        write;
        logic        address_space;
        logic        burst_type;
        logic [15:0] burst;
        logic [31:0] address;
    } hyper_tf_t;

    typedef struct packed {
        logic [3:0]  t_latency_access;
        logic [15:0] t_cs_max;
        logic [3:0]  t_read_write_recovery;
    } hyper_cfg_t;

    localparam int unsigned TfWidth  = $bits(hyper_tf_t);
    localparam int unsigned CfgWidth = $bits(hyper_cfg_t);

endpackage

// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no owner; round-robin grant to a valid requester
// ISSUE   | descriptor presented to the PHY, waiting for phy_tf_ready_i
// ACTIVE  | PHY owns the transfer, waiting for phy_done_i
// RECOVER | read-write recovery countdown before the next grant
module hyperbus_tf_sched #(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned IdWidth = $clog2(NumReq)
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic [hyperbus_tf_sched_pkg::CfgWidth-1:0]          cfg_i,
    input  logic [NumReq*hyperbus_tf_sched_pkg::TfWidth-1:0]    req_tf_i,
    input  logic [NumReq-1:0]                                   req_valid_i,
    output logic [NumReq-1:0]                                   req_ready_o,
    output logic [hyperbus_tf_sched_pkg::TfWidth-1:0]           phy_tf_o,
    output logic                                                phy_tf_valid_o,
    input  logic                                                phy_tf_ready_i,
    input  logic                                                phy_done_i,
    output logic [IdWidth-1:0]                                  grant_id_o,
    output logic                                                busy_o
);
    import hyperbus_tf_sched_pkg::*;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [TfWidth-1:0] tf_q, tf_d;
    logic [IdWidth-1:0] grant_q, grant_d;
    logic [IdWidth-1:0] last_grant_q, last_grant_d;
    logic [3:0]         cnt_q, cnt_d;

    hyper_cfg_t         cfg;
    logic [3:0]         cfg_rwr;
    logic               unused_cfg;

    assign cfg        = hyper_cfg_t'(cfg_i);
    assign cfg_rwr    = cfg.t_read_write_recovery;
    assign unused_cfg = ^{cfg.t_latency_access, cfg.t_cs_max};

    logic [TfWidth-1:0] req_tf [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign req_tf[g] = req_tf_i[g*TfWidth +: TfWidth];
    end

    // Round-robin pick: search from last_grant+1 upward, wrapping once.
    logic [IdWidth-1:0] winner;
    logic               any_valid;

    always_comb begin : rr_pick
        int unsigned        idx;
        logic [IdWidth-1:0] cand;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = int'(last_grant_q) + 1 + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            cand = IdWidth'(idx);
            if (!any_valid && req_valid_i[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Ready is qualified with reset so nothing is accepted while it is held.
    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && any_valid && !rst_i) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        tf_d         = tf_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    tf_d         = req_tf[winner];
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (phy_tf_ready_i) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (phy_done_i) begin
                    if (cfg_rwr == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cfg_rwr;
                        state_d = RECOVER;
                    end
                end
            end
            RECOVER: begin
                // Count is private to the FSM, so cfg_i changes here are ignored.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tf_q         <= '0;
            grant_q      <= '0;
            last_grant_q <= IdWidth'(NumReq - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tf_q         <= tf_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign phy_tf_o       = tf_q;
    assign phy_tf_valid_o = (state_q == ISSUE);
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_hyperbus_tf_sched.sv
module tb_hyperbus_tf_sched;
    import hyperbus_tf_sched_pkg::*;

    localparam int NumReq = 2;

    typedef struct packed {
        logic [0:0]         id;
        logic [TfWidth-1:0] tf;
    } exp_t;

    logic                      clk;
    logic                      rst;
    hyper_cfg_t                cfg;
    logic [NumReq*TfWidth-1:0] req_tf;
    logic [NumReq-1:0]         req_valid;
    logic [NumReq-1:0]         req_ready;
    logic [TfWidth-1:0]        phy_tf;
    logic                      phy_tf_valid;
    logic                      phy_tf_ready;
    logic                      phy_done;
    logic [0:0]                grant_id;
    logic                      busy;

    hyper_tf_t tf0, tf1, tf0_alt;
    exp_t      exp_q[$];
    int        tests = 0;
    int        fails = 0;

    hyperbus_tf_sched #(.NumReq(NumReq)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_i          (cfg),
        .req_tf_i       (req_tf),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .phy_tf_o       (phy_tf),
        .phy_tf_valid_o (phy_tf_valid),
        .phy_tf_ready_i (phy_tf_ready),
        .phy_done_i     (phy_done),
        .grant_id_o     (grant_id),
        .busy_o         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [0:0] id, input hyper_tf_t tf);
        exp_t e;
        e.id = id;
        e.tf = tf;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_tf"}, 64'(phy_tf), 64'd0);
        check({tag, "_valid"}, 64'(phy_tf_valid), 64'd0);
        check({tag, "_gid"}, 64'(grant_id), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: every PHY handshake must match the next expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && phy_tf_valid && phy_tf_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_handshake: got id %0d tf %0h expected none", grant_id, phy_tf);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant_id", 64'(grant_id), 64'(e.id));
                    check("sb_phy_tf", 64'(phy_tf), 64'(e.tf));
                end
            end
        end
    end

    initial begin
        int vcount;
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        tf0     = '{write: 1'b0, address_space: 1'b0, burst_type: 1'b1, burst: 16'd3,  address: 32'h0000_0040};
        tf1     = '{write: 1'b1, address_space: 1'b0, burst_type: 1'b0, burst: 16'd7,  address: 32'h0000_0100};
        tf0_alt = '{write: 1'b1, address_space: 1'b1, burst_type: 1'b0, burst: 16'hA5, address: 32'hDEAD_0000};
        req_tf       = {tf1, tf0};
        cfg          = '{t_latency_access: 4'd6, t_cs_max: 16'd665, t_read_write_recovery: 4'd0};
        rst          = 1'b1;
        req_valid    = 2'b11;
        phy_tf_ready = 1'b0;
        phy_done     = 1'b0;

        // Reset held 3 cycles with all valids high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset");
            cyc_end();
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_ready", 64'(req_ready), 64'h1);
        push_exp(1'b0, tf0);
        cyc_end();
        req_valid    = 2'b00;
        phy_tf_ready = 1'b1;
        @(negedge clk);
        check("first_issue_valid", 64'(phy_tf_valid), 64'd1);
        check("first_busy", 64'(busy), 64'd1);
        cyc_end();
        phy_done = 1'b1;
        cyc_end();
        phy_done = 1'b0;
        @(negedge clk);
        check("first_idle_busy", 64'(busy), 64'd0);

        // Single transfer from requester 1
        cyc_end();
        req_valid = 2'b10;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'h2);
        push_exp(1'b1, tf1);
        cyc_end();
        req_valid = 2'b00;
        vcount = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            vcount += int'(phy_tf_valid);
            cyc_end();
        end
        phy_done = 1'b1;
        @(negedge clk);
        check("single_gid", 64'(grant_id), 64'd1);
        check("single_busy_done", 64'(busy), 64'd1);
        check("single_tf_hold", 64'(phy_tf), 64'(tf1));
        cyc_end();
        phy_done = 1'b0;
        @(negedge clk);
        check("single_busy_fall", 64'(busy), 64'd0);
        check("single_valid_cycles", 64'(vcount), 64'd1);

        // Round-robin, both requesting continuously
        cyc_end();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ready", 64'(req_ready), 64'(rr_exp[k]));
            push_exp(rr_exp[k] == 2'b10 ? 1'b1 : 1'b0, rr_exp[k] == 2'b10 ? tf1 : tf0);
            cyc_end();
            @(negedge clk);
            check("rr_no_ready_issue", 64'(req_ready), 64'd0);
            cyc_end();
            phy_done = 1'b1;
            cyc_end();
            phy_done = 1'b0;
        end
        req_valid = 2'b00;

        // Recovery gap R=3, cfg changed to 0 during Recover
        cfg.t_read_write_recovery = 4'd3;
        req_valid = 2'b01;
        @(negedge clk);
        check("rec_ready0", 64'(req_ready), 64'h1);
        push_exp(1'b0, tf0);
        cyc_end();
        req_valid = 2'b10;
        cyc_end();
        phy_done = 1'b1;
        cyc_end();
        phy_done = 1'b0;
        cfg.t_read_write_recovery = 4'd0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("rec_busy", 64'(busy), 64'd1);
            check("rec_no_ready", 64'(req_ready), 64'd0);
            cyc_end();
        end
        @(negedge clk);
        check("rec_ready1", 64'(req_ready), 64'h2);
        check("rec_idle_busy", 64'(busy), 64'd0);
        push_exp(1'b1, tf1);
        cyc_end();
        req_valid = 2'b00;
        cyc_end();
        phy_done = 1'b1;
        cyc_end();
        phy_done = 1'b0;

        // PHY backpressure, stray done during Issue, source descriptor changes
        req_valid    = 2'b01;
        phy_tf_ready = 1'b0;
        @(negedge clk);
        check("bp_ready", 64'(req_ready), 64'h1);
        push_exp(1'b0, tf0);
        cyc_end();
        req_valid = 2'b00;
        req_tf    = {tf1, tf0_alt};
        for (int j = 0; j < 6; j++) begin
            phy_done = (j == 2);
            @(negedge clk);
            check("bp_valid", 64'(phy_tf_valid), 64'd1);
            check("bp_tf_stable", 64'(phy_tf), 64'(tf0));
            cyc_end();
        end
        phy_done     = 1'b0;
        phy_tf_ready = 1'b1;
        @(negedge clk);
        check("bp_still_issue", 64'(phy_tf_valid), 64'd1);
        cyc_end();
        @(negedge clk);
        check("bp_active_valid", 64'(phy_tf_valid), 64'd0);
        check("bp_active_busy", 64'(busy), 64'd1);
        phy_done = 1'b1;
        cyc_end();
        phy_done = 1'b0;
        req_tf   = {tf1, tf0};
        @(negedge clk);
        check("bp_idle_busy", 64'(busy), 64'd0);

        // Mid-op reset while Active
        cyc_end();
        req_valid = 2'b10;
        @(negedge clk);
        check("mr_ready", 64'(req_ready), 64'h2);
        push_exp(1'b1, tf1);
        cyc_end();
        req_valid = 2'b11;
        cyc_end();
        @(negedge clk);
        check("mr_active_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        cyc_end();
        rst = 1'b0;
        @(negedge clk);
        check("mr_first_ready", 64'(req_ready), 64'h1);
        push_exp(1'b0, tf0);
        cyc_end();
        req_valid = 2'b00;
        cyc_end();
        phy_done = 1'b1;
        cyc_end();
        phy_done = 1'b0;
        for (int j = 0; j < 4; j++) cyc_end();
        @(negedge clk);
        check("mr_no_reissue_busy", 64'(busy), 64'd0);
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
